perf_cnt_bank: RTL
==================

PERF_CNT_BANK -- requirements
Module: perf_cnt_bank

Interface
REQ-001 The module SHALL have parameter C_CNT_NUM, default C_PERF_CNT_CNT, giving the number of counters.
REQ-002 The module SHALL have parameter C_CNT_WDT, default C_PERF_CNT_WDT (48), giving the counter width.
REQ-003 The module SHALL have port clk, input, 1, the single clock.
REQ-004 The module SHALL have port rst_n, input, 1, the reset, asynchronous and active-low.
REQ-005 The module SHALL have port perf_evnt_in, input, C_CNT_NUM, one event per counter, indexed by the C_PERF_*_OFFSET constants.
REQ-006 The module SHALL have port regmap_wr_en, input, 1, a register write strobe.
REQ-007 The module SHALL have port regmap_wr_addr, input, 32, the byte write address.
REQ-008 The module SHALL have port regmap_wr_data, input, 32, the write data.
REQ-009 The module SHALL have port regmap_rd_en, input, 1, a register read strobe.
REQ-010 The module SHALL have port regmap_rd_addr, input, 32, the byte read address.
REQ-011 The module SHALL have port regmap_rd_data, output, 32, the read data.
REQ-012 The module SHALL have port regmap_rd_vld, output, 1, read data valid.

Function
REQ-013 Counter k SHALL own three words at C_PERF_RUN_CTRL_REG_ADDR + 12*k, in this order: CTRL (+0), LH (+4), UH (+8).
- The top of the window is C_PERF_CACHE_STALL_UH_REG_ADDR.
REQ-014 The CTRL word SHALL use these bits; all other bits SHALL read 0:
- bit0 EN: read/write.
- bit1 CLR: write-1 pulse, reads 0.
- bit2 OVF: sticky, write-1-to-clear.
REQ-015 When EN=1 and perf_evnt_in[k]=1 in a cycle, counter k SHALL increment by 1 at the next clk edge.
REQ-016 The counter SHALL wrap from 2^48-1 to 0 and set OVF in the same cycle.
REQ-017 When CLR and an event occur in the same cycle, CLR SHALL win: the counter becomes 0 and the event is dropped.
REQ-018 A CTRL write SHALL take effect from the cycle after the write; an event in the write cycle SHALL use the old EN.
REQ-019 When an OVF W1C coincides with a wrap, the wrap SHALL win and OVF stays 1.
REQ-020 An LH read SHALL return counter bits 31:0 and latch bits 47:32 into a per-counter shadow register.
REQ-021 A UH read SHALL return the shadow register zero-extended to 32 bits, so that an LH-then-UH read pair is coherent.
REQ-022 The shadow register SHALL reset to 0, and a UH read with no prior LH read SHALL return 0.
REQ-023 Read latency SHALL be exactly 1 cycle: regmap_rd_vld is high for one cycle after regmap_rd_en, with regmap_rd_data valid in that cycle.
REQ-024 When regmap_rd_vld is 0, regmap_rd_data SHALL be 0.
REQ-025 A read in the same cycle as a write or event to the same counter SHALL return the pre-update value.
REQ-026 A read outside the window, or at an address that is not 4-byte aligned, SHALL return 0 with regmap_rd_vld=1.
REQ-027 Writes to LH, UH, or addresses outside the window SHALL be ignored.
REQ-028 Back-to-back reads SHALL be accepted every cycle.

Reset
REQ-029 Asserting rst_n low SHALL asynchronously clear all counters, EN, OVF, the shadow registers, regmap_rd_data and regmap_rd_vld to 0.
REQ-030 A read in flight when reset asserts SHALL be discarded, with no regmap_rd_vld after reset release.
REQ-031 Counting SHALL resume only after software sets EN.

Structure
REQ-032 The package perf_cnt_pckg SHALL hold:
- the CTRL bit positions C_PERF_CTRL_EN_BIT, C_PERF_CTRL_CLR_BIT and C_PERF_CTRL_OVF_BIT;
- the word offsets C_PERF_WORD_CTRL, C_PERF_WORD_LH and C_PERF_WORD_UH;
- a packed struct type for the CTRL fields.
REQ-033 A sub-module perf_cnt_unit SHALL implement one counter (enable, clear, wrap, OVF and shadow register), instantiated C_CNT_NUM times by a generate loop.
REQ-034 perf_cnt_bank SHALL own the address decode and the read mux.

Verification
REQ-035 Write CTRL[0]=0x1, then drive 100 events on index 1 -> an LH read at the k=1 address returns 100 and UH returns 0.
REQ-036 Preload a counter to 0xFFFF_FFFF_FFFF by forcing it, then drive 1 event -> LH=0, UH=0, CTRL reads 0x5 (EN and OVF set).
REQ-037 Write CLR in the same cycle as an event -> LH=0.
REQ-038 Write 0x4 to CTRL -> OVF reads 0.
REQ-039 Counter at 0x0000_FFFF_FFFF with continuous events:
- an LH read returns 0xFFFF_FFFF;
- a UH read 3 cycles later returns 0x0, not 0x1.
REQ-040 Assert rst_n low mid-read with a continuous event stream -> regmap_rd_vld stays 0, all registers read 0 after release, and no counting occurs until EN is written.

Source files
------------

// File: rtl/perf_cnt_pckg.sv
// ---------------------------------------------------------------------------
// perf_cnt_pckg
// Shared constants and types for the performance-counter bank.
//   - counter count/width defaults and the per-event index offsets
//   - register map: base CTRL address of each counter, top of the window
//   - CTRL bit positions, word offsets within a counter's 12-byte slot
//   - perf_ctrl_t: packed view of the CTRL word
//   - perf_word_addr(): byte address of word <word> of counter <idx>
// ---------------------------------------------------------------------------
package perf_cnt_pckg;

    // Bank geometry
    localparam int C_PERF_CNT_CNT = 4;
    localparam int C_PERF_CNT_WDT = 48;

    // Index of each event in perf_evnt_in
    localparam int C_PERF_RUN_OFFSET         = 0;
    localparam int C_PERF_INSTR_OFFSET       = 1;
    localparam int C_PERF_MEM_STALL_OFFSET   = 2;
    localparam int C_PERF_CACHE_STALL_OFFSET = 3;

    // Word offsets inside one counter's slot
    localparam logic [31:0] C_PERF_WORD_CTRL  = 32'd0;
    localparam logic [31:0] C_PERF_WORD_LH    = 32'd4;
    localparam logic [31:0] C_PERF_WORD_UH    = 32'd8;
    localparam logic [31:0] C_PERF_CNT_STRIDE = 32'd12;

    // Register map
    localparam logic [31:0] C_PERF_RUN_CTRL_REG_ADDR         = 32'h0000_0100;
    localparam logic [31:0] C_PERF_INSTR_CTRL_REG_ADDR       = 32'h0000_010C;
    localparam logic [31:0] C_PERF_MEM_STALL_CTRL_REG_ADDR   = 32'h0000_0118;
    localparam logic [31:0] C_PERF_CACHE_STALL_CTRL_REG_ADDR = 32'h0000_0124;
    localparam logic [31:0] C_PERF_CACHE_STALL_UH_REG_ADDR   = 32'h0000_012C;

    // CTRL bit positions
    localparam int C_PERF_CTRL_EN_BIT  = 0;
    localparam int C_PERF_CTRL_CLR_BIT = 1;
    localparam int C_PERF_CTRL_OVF_BIT = 2;

    typedef struct packed {
        logic [28:0] rsvd;
        logic        ovf;
        logic        clr;
        logic        en;
    } perf_ctrl_t;

    function automatic logic [31:0] perf_word_addr(input int idx, input logic [31:0] word);
        return C_PERF_RUN_CTRL_REG_ADDR + (C_PERF_CNT_STRIDE * 32'(idx)) + word;
    endfunction

endpackage

// File: rtl/perf_cnt_unit.sv
// ---------------------------------------------------------------------------
// perf_cnt_unit
// One event counter with enable, clear pulse, wrap-around overflow flag and
// the upper-half shadow register used for coherent LH/UH read pairs.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   evnt          : event for this counter (counted when EN=1)
//   ctrl_wr       : CTRL word of this counter is being written this cycle
//   ctrl_wr_bits  : write data bits [2:0] (EN, CLR, OVF-W1C)
//   lh_rd         : LH word of this counter is being read this cycle
//   cnt_lo        : counter bits 31:0
//   en, ovf       : current EN and OVF state
//   shadow        : upper counter bits latched by the last LH read
// ---------------------------------------------------------------------------
module perf_cnt_unit
    import perf_cnt_pckg::*;
#(
    parameter int C_CNT_WDT = C_PERF_CNT_WDT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  evnt,
    input  logic                  ctrl_wr,
    input  logic [2:0]            ctrl_wr_bits,
    input  logic                  lh_rd,
    output logic [31:0]           cnt_lo,
    output logic                  en,
    output logic                  ovf,
    output logic [C_CNT_WDT-33:0] shadow
);

    logic [C_CNT_WDT-1:0]  cnt_q;
    logic                  en_q;
    logic                  ovf_q;
    logic [C_CNT_WDT-33:0] shadow_q;

    logic clr_req;
    logic ovf_w1c;
    logic inc;
    logic wrap;

    // EN in use this cycle is the registered one, so a CTRL write only
    // affects counting from the following cycle.
    assign clr_req = ctrl_wr & ctrl_wr_bits[C_PERF_CTRL_CLR_BIT];
    assign ovf_w1c = ctrl_wr & ctrl_wr_bits[C_PERF_CTRL_OVF_BIT];
    assign inc     = en_q & evnt;
    // A clear drops the coincident event, so no wrap can happen then.
    assign wrap    = inc & ~clr_req & (&cnt_q);

    // Stage boundary: counter state updated at the clock edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            en_q     <= 1'b0;
            ovf_q    <= 1'b0;
            shadow_q <= '0;
        end else begin
            if (clr_req) begin
                cnt_q <= '0;
            end else if (inc) begin
                cnt_q <= cnt_q + C_CNT_WDT'(1);
            end

            if (ctrl_wr) begin
                en_q <= ctrl_wr_bits[C_PERF_CTRL_EN_BIT];
            end

            // Wrap has priority over the software clear of OVF.
            if (wrap) begin
                ovf_q <= 1'b1;
            end else if (ovf_w1c) begin
                ovf_q <= 1'b0;
            end

            // Latch the pre-update upper bits so they pair with the LH value.
            if (lh_rd) begin
                shadow_q <= cnt_q[C_CNT_WDT-1:32];
            end
        end
    end

    assign cnt_lo = cnt_q[31:0];
    assign en     = en_q;
    assign ovf    = ovf_q;
    assign shadow = shadow_q;

endmodule

// File: rtl/perf_cnt_bank.sv
// ---------------------------------------------------------------------------
// perf_cnt_bank
// Bank of C_CNT_NUM performance counters behind a simple register port.
// Each counter owns three words: CTRL (+0), LH (+4), UH (+8), with a
// 12-byte stride starting at C_PERF_RUN_CTRL_REG_ADDR.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   perf_evnt_in    : one event bit per counter
//   regmap_wr_en    : write strobe; regmap_wr_addr/regmap_wr_data
//   regmap_rd_en    : read strobe; regmap_rd_addr
//   regmap_rd_data  : read data, valid (and non-zero only) with regmap_rd_vld
//   regmap_rd_vld   : one cycle after each regmap_rd_en
// ---------------------------------------------------------------------------
module perf_cnt_bank
    import perf_cnt_pckg::*;
#(
    parameter int C_CNT_NUM = C_PERF_CNT_CNT,
    parameter int C_CNT_WDT = C_PERF_CNT_WDT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [C_CNT_NUM-1:0] perf_evnt_in,
    input  logic                 regmap_wr_en,
    input  logic [31:0]          regmap_wr_addr,
    input  logic [31:0]          regmap_wr_data,
    input  logic                 regmap_rd_en,
    input  logic [31:0]          regmap_rd_addr,
    output logic [31:0]          regmap_rd_data,
    output logic                 regmap_rd_vld
);

    perf_ctrl_t            wr_ctrl;
    logic [2:0]            wr_ctrl_bits;
    logic                  unused_wr_rsvd;

    logic [C_CNT_NUM-1:0]  ctrl_wr_p0;
    logic [C_CNT_NUM-1:0]  lh_rd_p0;
    logic [C_CNT_NUM-1:0]  cnt_en;
    logic [C_CNT_NUM-1:0]  cnt_ovf;
    logic [31:0]           cnt_lo [C_CNT_NUM];
    logic [C_CNT_WDT-33:0] cnt_shadow [C_CNT_NUM];

    perf_ctrl_t            ctrl_rd_p0;
    logic [31:0]           rd_data_p0;
    logic [31:0]           rd_data_p1;
    logic                  rd_vld_p1;

    assign wr_ctrl        = perf_ctrl_t'(regmap_wr_data);
    assign wr_ctrl_bits   = {wr_ctrl.ovf, wr_ctrl.clr, wr_ctrl.en};
    assign unused_wr_rsvd = ^wr_ctrl.rsvd;

    // Stage p0: address decode. Exact matches against aligned word
    // addresses make unaligned and out-of-window accesses fall through,
    // so LH/UH writes and stray addresses are ignored naturally.
    always_comb begin
        ctrl_wr_p0 = '0;
        lh_rd_p0   = '0;
        for (int k = 0; k < C_CNT_NUM; k++) begin
            ctrl_wr_p0[k] = regmap_wr_en && (regmap_wr_addr == perf_word_addr(k, C_PERF_WORD_CTRL));
            lh_rd_p0[k]   = regmap_rd_en && (regmap_rd_addr == perf_word_addr(k, C_PERF_WORD_LH));
        end
    end

    // Stage p0: read mux over the pre-update counter state.
    always_comb begin
        rd_data_p0 = '0;
        ctrl_rd_p0 = '0;
        for (int k = 0; k < C_CNT_NUM; k++) begin
            if (regmap_rd_addr == perf_word_addr(k, C_PERF_WORD_CTRL)) begin
                ctrl_rd_p0     = '0;
                ctrl_rd_p0.en  = cnt_en[k];
                ctrl_rd_p0.ovf = cnt_ovf[k];
                rd_data_p0     = ctrl_rd_p0;
            end else if (regmap_rd_addr == perf_word_addr(k, C_PERF_WORD_LH)) begin
                rd_data_p0 = cnt_lo[k];
            end else if (regmap_rd_addr == perf_word_addr(k, C_PERF_WORD_UH)) begin
                rd_data_p0                  = '0;
                rd_data_p0[C_CNT_WDT-33:0]  = cnt_shadow[k];
            end
        end
    end

    for (genvar k = 0; k < C_CNT_NUM; k++) begin : g_cnt
        perf_cnt_unit #(
            .C_CNT_WDT (C_CNT_WDT)
        ) u_cnt (
            .clk          (clk),
            .rst_n        (rst_n),
            .evnt         (perf_evnt_in[k]),
            .ctrl_wr      (ctrl_wr_p0[k]),
            .ctrl_wr_bits (wr_ctrl_bits),
            .lh_rd        (lh_rd_p0[k]),
            .cnt_lo       (cnt_lo[k]),
            .en           (cnt_en[k]),
            .ovf          (cnt_ovf[k]),
            .shadow       (cnt_shadow[k])
        );
    end

    // Stage p1: registered read response, zero whenever not valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_p1  <= 1'b0;
            rd_data_p1 <= '0;
        end else begin
            rd_vld_p1  <= regmap_rd_en;
            rd_data_p1 <= regmap_rd_en ? rd_data_p0 : '0;
        end
    end

    assign regmap_rd_data = rd_data_p1;
    assign regmap_rd_vld  = rd_vld_p1;

endmodule
